// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD command path: FSM states, frame
// geometry, CRC7 polynomial and the command indices used by the sequencer.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        HDR  = 3'd2,
        CRC  = 3'd3,
        STOP = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int unsigned FRAME_BITS = 48;
    localparam int unsigned HDR_BITS   = 40;
    localparam int unsigned CRC_BITS   = 7;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    // Start bit, transmission bit, index and argument: the CRC-covered part.
    function automatic logic [HDR_BITS-1:0] hdr_word(input logic [5:0] cmd,
                                                     input logic [31:0] arg);
        return {2'b01, cmd, arg};
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1) LFSR, one data bit per enabled cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : shift din into the CRC this cycle
//   din        : serial data bit
//   crc        : current CRC remainder
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;

    assign fb = din ^ crc[6];

    // Shift left, folding the feedback into taps x^3 and x^0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 7'h00;
        end else if (clr) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_tx.sv
// SPI-mode SD command transmitter: sends optional DI-high preamble bits,
// then the 48-bit command frame MSB-first with hardware-generated CRC7.
// Ports:
//   clk, rst_n : clock (one SPI bit per cycle), async active-low reset
//   isStart    : send request, sampled only while idle
//   cmd, arg   : command index and argument, captured on the accepting edge
//   DI         : serial data to the card, idles high
//   CS_n       : card select, low from preamble through the end bit
//   isBusy     : frame in progress
//   isFinish   : sticky done flag, cleared by the next accepted request
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int unsigned PRE_CLOCKS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        isStart,
    input  logic [5:0]  cmd,
    input  logic [31:0] arg,
    output logic        DI,
    output logic        CS_n,
    output logic        isBusy,
    output logic        isFinish
);

    localparam int unsigned CNT_MAX = (PRE_CLOCKS > HDR_BITS) ? PRE_CLOCKS : HDR_BITS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [HDR_BITS-1:0] sr, sr_d;
    logic                di_d, cs_n_d, busy_d, fin_d;
    logic                crc_clr, crc_en;
    logic [6:0]          crc;
    logic [2:0]          crc_idx;

    // CRC bits go out MSB-first by index so the remainder stays frozen.
    assign crc_idx = 3'(CRC_BITS - 1) - cnt[2:0];

    sd_crc7 u_crc7 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (sr[HDR_BITS-1]),
        .crc   (crc)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            DI       <= 1'b1;
            CS_n     <= 1'b1;
            isBusy   <= 1'b0;
            isFinish <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            sr       <= sr_d;
            DI       <= di_d;
            CS_n     <= cs_n_d;
            isBusy   <= busy_d;
            isFinish <= fin_d;
        end
    end

    // Next state and next registered output values.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sr_d    = sr;
        di_d    = 1'b1;
        cs_n_d  = CS_n;
        busy_d  = isBusy;
        fin_d   = isFinish;
        crc_clr = 1'b0;
        crc_en  = 1'b0;

        case (state)
            IDLE: begin
                if (isStart) begin
                    sr_d    = hdr_word(cmd, arg);
                    crc_clr = 1'b1;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    fin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = (PRE_CLOCKS == 0) ? HDR : PRE;
                end
            end
            PRE: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(PRE_CLOCKS - 1)) begin
                    cnt_d   = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                di_d   = sr[HDR_BITS-1];
                crc_en = 1'b1;
                sr_d   = {sr[HDR_BITS-2:0], 1'b0};
                cnt_d  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(HDR_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = CRC;
                end
            end
            CRC: begin
                di_d  = crc[crc_idx];
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(CRC_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                state_d = DONE;
            end
            DONE: begin
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                fin_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sr_d    = '0;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                fin_d   = 1'b0;
                crc_clr = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Self-checking bench for sd_cmd_tx: directed SD commands with known CRCs,
// mid-frame request rejection, back-to-back frames, async abort and random
// frames against a reference CRC7 model via an expected-frame scoreboard.
module tb_sd_cmd_tx;
    import sd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_start, b_start;
    logic [5:0]  a_cmd, b_cmd;
    logic [31:0] a_arg, b_arg;
    logic        a_di, a_cs_n, a_busy, a_fin;
    logic        b_di, b_cs_n, b_busy, b_fin;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned viol   = 0;

    logic [47:0] exp_q[$];

    always #5 clk = ~clk;

    sd_cmd_tx #(.PRE_CLOCKS(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .isStart(a_start), .cmd(a_cmd), .arg(a_arg),
        .DI(a_di), .CS_n(a_cs_n), .isBusy(a_busy), .isFinish(a_fin)
    );

    sd_cmd_tx #(.PRE_CLOCKS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .isStart(b_start), .cmd(b_cmd), .arg(b_arg),
        .DI(b_di), .CS_n(b_cs_n), .isBusy(b_busy), .isFinish(b_fin)
    );

    // DI must be high whenever the card is deselected.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ((a_cs_n && !a_di) || (b_cs_n && !b_di)))
            viol++;
    end

    function automatic logic [47:0] ref_frame(input logic [5:0] c, input logic [31:0] a);
        logic [39:0] h;
        logic [6:0]  r;
        logic        fb;
        h = {2'b01, c, a};
        r = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = h[i] ^ r[6];
            r  = {r[5:0], 1'b0};
            if (fb) r = r ^ 7'h09;
        end
        return {h, r, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic [3:0] a_out();
        return {a_di, a_cs_n, a_busy, a_fin};
    endfunction

    function automatic logic [3:0] b_out();
        return {b_di, b_cs_n, b_busy, b_fin};
    endfunction

    // One frame on the PRE_CLOCKS=8 instance; poke >= 0 re-requests at that bit.
    task automatic frame_a(input logic [5:0] c, input logic [31:0] a,
                           input logic [47:0] exp, input int poke);
        logic [47:0] got;
        logic        ok;
        @(negedge clk);
        a_start = 1'b1; a_cmd = c; a_arg = a;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        a_start = 1'b0; a_cmd = 6'($urandom); a_arg = $urandom;
        @(negedge clk);
        check("accept", 48'(a_out()), 48'(4'b1010));
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_out() !== 4'b1010) ok = 1'b0;
        end
        got = '0;
        for (int b = 47; b >= 0; b--) begin
            @(negedge clk);
            got[b] = a_di;
            if (a_cs_n !== 1'b0 || a_busy !== 1'b1 || a_fin !== 1'b0) ok = 1'b0;
            a_start = (poke >= 0 && b == poke) ? 1'b1 : 1'b0;
            if (a_start) begin a_cmd = 6'($urandom); a_arg = $urandom; end
        end
        check("frame_ctrl", 48'(ok), 48'(1));
        check("frame_data", got, exp_q.pop_front());
        @(negedge clk);
        check("done", 48'(a_out()), 48'(4'b1101));
        @(negedge clk);
        check("idle_sticky", 48'(a_out()), 48'(4'b1101));
    endtask

    initial begin
        logic [47:0] got;
        logic [5:0]  rc;
        logic [31:0] ra;

        rst_n = 1'b0;
        a_start = 1'b0; a_cmd = '0; a_arg = '0;
        b_start = 1'b0; b_cmd = '0; b_arg = '0;
        repeat (2) @(negedge clk);
        check("reset_a", 48'(a_out()), 48'(4'b1100));
        check("reset_b", 48'(b_out()), 48'(4'b1100));
        rst_n = 1'b1;

        frame_a(CMD0,  32'h0000_0000, 48'h40_0000_0000_95, -1);
        frame_a(CMD8,  32'h0000_01AA, 48'h48_0000_01AA_87, -1);
        frame_a(CMD55, 32'h0000_0000, 48'h77_0000_0000_65, 30);

        // PRE_CLOCKS=0 with request held: two frames, one idle gap cycle.
        @(negedge clk);
        b_start = 1'b1; b_cmd = CMD8; b_arg = 32'h0000_01AA;
        exp_q.push_back(48'h48_0000_01AA_87);
        @(posedge clk); #1;
        b_cmd = CMD55; b_arg = 32'h0;
        exp_q.push_back(48'h77_0000_0000_65);
        @(negedge clk);
        check("b2b_accept1", 48'(b_out()), 48'(4'b1010));
        for (int b = 47; b >= 0; b--) begin @(negedge clk); got[b] = b_di; end
        check("b2b_frame1", got, exp_q.pop_front());
        @(negedge clk);
        check("b2b_gap", 48'(b_out()), 48'(4'b1101));
        @(negedge clk);
        check("b2b_accept2", 48'(b_out()), 48'(4'b1010));
        for (int b = 47; b >= 0; b--) begin
            @(negedge clk); got[b] = b_di;
            if (b == 0) b_start = 1'b0;
        end
        check("b2b_frame2", got, exp_q.pop_front());
        @(negedge clk);
        check("b2b_done", 48'(b_out()), 48'(4'b1101));
        @(negedge clk);
        check("b2b_no_rearm", 48'(b_out()), 48'(4'b1101));

        // Abort at frame bit 20, then a clean CMD0.
        @(negedge clk);
        a_start = 1'b1; a_cmd = CMD17; a_arg = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (9 + 28) @(negedge clk);
        check("abort_busy", 48'(a_out()), 48'(4'b0010) | 48'({a_di, 3'b000}));
        #2 rst_n = 1'b0;
        #1;
        check("abort_async", 48'(a_out()), 48'(4'b1100));
        @(negedge clk);
        rst_n = 1'b1;
        frame_a(CMD0, 32'h0000_0000, 48'h40_0000_0000_95, -1);

        for (int n = 0; n < 1000; n++) begin
            rc = 6'($urandom);
            ra = $urandom;
            frame_a(rc, ra, ref_frame(rc, ra), -1);
        end

        check("di_high_when_deselected", 48'(viol), 48'(0));
        check("queue_empty", 48'(exp_q.size()), 48'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
